// File: rtl/xls_test_unroll_stream_sink.sv
// ---------------------------------------------------------------------------
// xls_test_unroll_stream_sink
//
// Streaming wrapper around a fixed-latency, valid-less pipeline
// (xls_test_unroll, out = 496*x). Operands arrive on a ready/valid port and go
// straight into the pipeline. A shift register of the same length as the
// pipeline marks which slots hold accepted operands. When a marked slot reaches
// the pipeline output, its result is written into a small FIFO. The FIFO drives
// a ready/valid result port.
//
// Admission is credit based. An operand is accepted only while the queued
// results plus the in-flight operands leave room in the FIFO. As a result, a
// result is never dropped, however long the downstream stalls.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream operand valid
//   in_ready   upstream may transfer this cycle
//   in_data    upstream operand x
//   pipe_x     operand to the pipeline x input (combinational from in_data)
//   pipe_out   result from the pipeline output
//   out_valid  result available at the FIFO head
//   out_ready  downstream accepts the head
//   out_data   FIFO head (show-ahead)
//   occupancy  FIFO entries plus in-flight operands
//   overflow   sticky flag; set if a result ever arrives at a full FIFO
// ---------------------------------------------------------------------------
module xls_test_unroll_stream_sink #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 6,
   parameter int DEPTH   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic [WIDTH-1:0]         pipe_x,
   input  logic [WIDTH-1:0]         pipe_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   // The sum is wide enough even if the pipeline is deeper than the FIFO.
   localparam int SW = $clog2(DEPTH + LATENCY + 1);

   // -----------------------------------------------------------------------
   // State
   // -----------------------------------------------------------------------
   logic [LATENCY-1:0] vld_q, vld_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               overflow_q, overflow_d;
   logic [WIDTH-1:0]   mem [DEPTH];

   logic               accept;
   logic               wr;
   logic               rd;
   logic               full;
   logic               wr_en;
   logic [SW-1:0]      inflight;
   logic [SW-1:0]      occ_sum;

   // The pipeline sees every cycle's operand. Only accepted ones are tracked.
   assign pipe_x = in_data;

   // -----------------------------------------------------------------------
   // Credit: in_ready depends only on registered state (and reset).
   // A pop in this cycle does not free a credit until the next cycle.
   // -----------------------------------------------------------------------
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight = inflight + SW'(vld_q[i]);
      end
      occ_sum = SW'(count_q) + inflight;
   end

   assign in_ready  = rst_n && (occ_sum < SW'(DEPTH));
   assign occupancy = occ_sum[CW-1:0];
   assign accept    = in_valid && in_ready;

   // -----------------------------------------------------------------------
   // Latency-matched valid shift register
   // -----------------------------------------------------------------------
   assign vld_d[0] = accept;
   generate
      for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vld
         assign vld_d[gi] = vld_q[gi-1];
      end
   endgenerate

   // -----------------------------------------------------------------------
   // Result FIFO
   // -----------------------------------------------------------------------
   assign wr        = vld_q[LATENCY-1];
   assign out_valid = (count_q != '0);
   assign rd        = out_valid && out_ready;
   assign full      = (count_q == CW'(DEPTH));
   // A write into a full FIFO succeeds only if a pop frees the slot on the same edge.
   assign wr_en     = wr && (!full || rd);
   assign out_data  = mem[rd_ptr_q];
   assign overflow  = overflow_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (wr && full && !rd);
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, rd})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         vld_q      <= vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage has no reset. Entries are only visible through count_q.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= pipe_out;
      end
   end

endmodule

// File: tb/tb_xls_test_unroll_stream_sink.sv
// ---------------------------------------------------------------------------
// Testbench for xls_test_unroll_stream_sink.
//
// The bench supplies its own 6-register pipeline, out = 496*x.
// Inputs change on the falling edge, and outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_xls_test_unroll_stream_sink;

   localparam int WIDTH   = 32;
   localparam int LATENCY = 6;
   localparam int DEPTH   = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;
   logic [WIDTH-1:0]  pipe_x;
   logic [WIDTH-1:0]  pipe_out;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic [3:0]        occupancy;
   logic              overflow;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [WIDTH-1:0]  exp_q [$];

   always #5 clk = ~clk;

   xls_test_unroll_stream_sink #(
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY),
      .DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .pipe_x    (pipe_x),
      .pipe_out  (pipe_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .overflow  (overflow)
   );

   // Attached pipeline: 6 registers with no reset and no valid.
   logic [WIDTH-1:0] pipe_q [LATENCY];
   always_ff @(posedge clk) begin
      pipe_q[0] <= pipe_x * 32'd496;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
   end
   assign pipe_out = pipe_q[LATENCY-1];

   task automatic drive(input logic v, input logic [31:0] d, input logic r);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests_run++;
      if (occupancy !== 4'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
      tests_run++;
      if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_single;
      logic       ev;
      logic [3:0] eo;
      for (int c = 0; c < 10; c++) begin
         drive(c == 0, 32'h1, 1'b1);
         if (c == 0) begin
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
         end
         ev = (c == 7);
         eo = (c >= 1 && c <= 7) ? 4'd1 : 4'd0;
         tests_run++;
         if (out_valid !== ev) begin tests_failed++; $display("FAIL single_out_valid c=%0d: got %b expected %b", c, out_valid, ev); end
         if (ev) begin
            tests_run++;
            if (out_data !== 32'h000001F0) begin tests_failed++; $display("FAIL single_out_data: got %h expected 000001f0", out_data); end
         end
         tests_run++;
         if (occupancy !== eo) begin tests_failed++; $display("FAIL single_occupancy c=%0d: got %0d expected %0d", c, occupancy, eo); end
      end
      $display("[TB] test_single done");
   endtask

   task automatic test_back_to_back;
      logic [31:0] xs [6] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'hFFFFFFFF, 32'h01000000};
      logic [31:0] ex [6] = '{32'h0, 32'h1F0, 32'h3E0, 32'h5D0, 32'hFFFFFE10, 32'hF0000000};
      logic        ev;
      for (int c = 0; c < 15; c++) begin
         drive(c < 6, (c < 6) ? xs[c] : 32'h0, 1'b1);
         if (c < 6) begin
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready c=%0d: got %b expected 1", c, in_ready); end
         end
         ev = (c >= 7 && c <= 12);
         tests_run++;
         if (out_valid !== ev) begin tests_failed++; $display("FAIL b2b_out_valid c=%0d: got %b expected %b", c, out_valid, ev); end
         if (ev) begin
            tests_run++;
            if (out_data !== ex[c-7]) begin tests_failed++; $display("FAIL b2b_out_data c=%0d: got %h expected %h", c, out_data, ex[c-7]); end
         end
      end
      $display("[TB] test_back_to_back done");
   endtask

   task automatic test_backpressure;
      logic        er;
      logic [31:0] ed;
      for (int c = 0; c < 20; c++) begin
         drive(1'b1, 32'(100 + c), 1'b0);
         er = (c < 8);
         tests_run++;
         if (in_ready !== er) begin tests_failed++; $display("FAIL bp_in_ready c=%0d: got %b expected %b", c, in_ready, er); end
      end
      tests_run++;
      if (occupancy !== 4'd8) begin tests_failed++; $display("FAIL bp_occupancy: got %0d expected 8", occupancy); end
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 32'h0, 1'b1);
         tests_run++;
         if (out_valid !== (i < 8)) begin tests_failed++; $display("FAIL bp_drain_valid i=%0d: got %b expected %b", i, out_valid, (i < 8)); end
         if (i < 8) begin
            ed = 32'(100 + i) * 32'd496;
            tests_run++;
            if (out_data !== ed) begin tests_failed++; $display("FAIL bp_drain_data i=%0d: got %h expected %h", i, out_data, ed); end
         end
         tests_run++;
         if (in_ready !== (i >= 1)) begin tests_failed++; $display("FAIL bp_drain_in_ready i=%0d: got %b expected %b", i, in_ready, (i >= 1)); end
      end
      tests_run++;
      if (overflow !== 1'b0) begin tests_failed++; $display("FAIL bp_overflow: got %b expected 0", overflow); end
      $display("[TB] test_backpressure done");
   endtask

   task automatic test_random;
      int          acc = 0;
      int          cyc = 0;
      logic [31:0] ed;
      exp_q.delete();
      while (acc < 10000 && cyc < 60000) begin
         drive(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
         tests_run++;
         if (occupancy > 4'd8) begin tests_failed++; $display("FAIL rand_occupancy cyc=%0d: got %0d expected <=8", cyc, occupancy); end
         if (in_valid && in_ready) begin exp_q.push_back(in_data * 32'd496); acc++; end
         if (out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++; $display("FAIL rand_spurious cyc=%0d: got %h expected no result", cyc, out_data);
            end else begin
               ed = exp_q.pop_front();
               if (out_data !== ed) begin tests_failed++; $display("FAIL rand_data cyc=%0d: got %h expected %h", cyc, out_data, ed); end
            end
         end
         cyc++;
      end
      cyc = 0;
      while (cyc < 100 && (exp_q.size() != 0 || occupancy != 4'd0)) begin
         drive(1'b0, 32'h0, 1'b1);
         if (out_valid) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++; $display("FAIL rand_drain_spurious: got %h expected no result", out_data);
            end else begin
               ed = exp_q.pop_front();
               if (out_data !== ed) begin tests_failed++; $display("FAIL rand_drain_data: got %h expected %h", out_data, ed); end
            end
         end
         cyc++;
      end
      tests_run++;
      if (acc != 10000) begin tests_failed++; $display("FAIL rand_accepts: got %0d expected 10000", acc); end
      tests_run++;
      if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rand_lost: got %0d outstanding expected 0", exp_q.size()); end
      tests_run++;
      if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rand_overflow: got %b expected 0", overflow); end
      $display("[TB] test_random done: %0d operands", acc);
   endtask

   task automatic test_reset_inflight;
      logic ev;
      exp_q.delete();
      for (int c = 0; c < 2; c++) drive(1'b1, 32'(7 + c), 1'b0);
      repeat (8) drive(1'b0, 32'h0, 1'b0);
      for (int c = 0; c < 3; c++) drive(1'b1, 32'(20 + c), 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      tests_run++;
      if (occupancy !== 4'd5) begin tests_failed++; $display("FAIL rst_pre_occupancy: got %0d expected 5", occupancy); end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_async_out_valid: got %b expected 0", out_valid); end
      tests_run++;
      if (occupancy !== 4'd0) begin tests_failed++; $display("FAIL rst_async_occupancy: got %0d expected 0", occupancy); end
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_async_in_ready: got %b expected 0", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         drive(1'b0, 32'h0, 1'b1);
         tests_run++;
         if (out_valid !== 1'b0 || occupancy !== 4'd0) begin
            tests_failed++; $display("FAIL rst_stale c=%0d: got valid=%b occ=%0d expected valid=0 occ=0", c, out_valid, occupancy);
         end
      end
      for (int c = 0; c < 10; c++) begin
         drive(c == 0, 32'h5, 1'b1);
         ev = (c == 7);
         tests_run++;
         if (out_valid !== ev) begin tests_failed++; $display("FAIL rst_next_valid c=%0d: got %b expected %b", c, out_valid, ev); end
         if (ev) begin
            tests_run++;
            if (out_data !== 32'h000009B0) begin tests_failed++; $display("FAIL rst_next_data: got %h expected 000009b0", out_data); end
         end
      end
      $display("[TB] test_reset_inflight done");
   endtask

   task automatic test_wrap;
      int          acc  = 0;
      int          pops = 0;
      int          cyc  = 0;
      logic [31:0] ed;
      exp_q.delete();
      while ((acc < 20 || pops < 20) && cyc < 300) begin
         drive(acc < 20, 32'h10000000 + 32'(acc * 3), 1'(((cyc / 5) % 2) == 1));
         if (in_valid && in_ready) begin exp_q.push_back(in_data * 32'd496); acc++; end
         if (out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++; $display("FAIL wrap_spurious cyc=%0d: got %h expected no result", cyc, out_data);
            end else begin
               ed = exp_q.pop_front();
               if (out_data !== ed) begin tests_failed++; $display("FAIL wrap_data pop=%0d: got %h expected %h", pops, out_data, ed); end
            end
            pops++;
         end
         cyc++;
      end
      tests_run++;
      if (pops != 20) begin tests_failed++; $display("FAIL wrap_pops: got %0d expected 20", pops); end
      drive(1'b0, 32'h0, 1'b1);
      tests_run++;
      if (occupancy !== 4'd0) begin tests_failed++; $display("FAIL wrap_occupancy: got %0d expected 0", occupancy); end
      tests_run++;
      if (overflow !== 1'b0) begin tests_failed++; $display("FAIL wrap_overflow: got %b expected 0", overflow); end
      $display("[TB] test_wrap done: %0d results", pops);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_inflight();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
